// File: rtl/track_section_arbiter.sv
// track_section_arbiter
//   Round-robin arbiter that hands one shared track section to one of
//   NUM_TRAINS trains at a time. It drives a go/stop code per train and
//   sets the section switches to the route of the train that holds the
//   section. A watchdog latches a sticky fault if the holder never exits.
//
// Ports
//   Clock     rising-edge clock
//   RESET     synchronous active-high reset
//   SR_ENTER  per-train approach sensor (level)
//   SR_EXIT   per-train exit sensor (level)
//   ROUTE     per-train switch setting, train i at [i*SW_WIDTH +: SW_WIDTH]
//   SW        registered switch setting for the section
//   D         registered drive code per train at [2i+1:2i]; 01 = go, 00 = stop
//   OWNER     index of the section holder, zero-extended to 3 bits
//   BUSY      section granted
//   FAULT     sticky watchdog fault, cleared only by RESET
module track_section_arbiter #(
  parameter int unsigned NUM_TRAINS     = 4,
  parameter int unsigned SW_WIDTH       = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned CNT_W          = 10
) (
  input  logic                           Clock,
  input  logic                           RESET,
  input  logic [NUM_TRAINS-1:0]          SR_ENTER,
  input  logic [NUM_TRAINS-1:0]          SR_EXIT,
  input  logic [NUM_TRAINS*SW_WIDTH-1:0] ROUTE,
  output logic [SW_WIDTH-1:0]            SW,
  output logic [2*NUM_TRAINS-1:0]        D,
  output logic [2:0]                     OWNER,
  output logic                           BUSY,
  output logic                           FAULT
);

  localparam int unsigned IW = $clog2(NUM_TRAINS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_CLEAR,
    S_FAULT
  } state_t;

  state_t                  r_state;
  logic [NUM_TRAINS-1:0]   r_pending;
  logic [IW-1:0]           r_last_owner;
  logic [IW-1:0]           r_owner;
  logic [CNT_W-1:0]        r_timer;
  logic [SW_WIDTH-1:0]     r_sw;
  logic [2*NUM_TRAINS-1:0] r_d;
  logic                    r_busy;
  logic                    r_fault;

  logic [NUM_TRAINS-1:0]   w_req;
  logic                    w_found;
  logic [IW-1:0]           w_winner;
  logic                    w_grant;
  logic                    w_owner_exit;
  logic                    w_timeout;
  logic                    w_fault_nxt;
  logic [IW-1:0]           w_owner_nxt;
  logic [NUM_TRAINS-1:0]   w_pending_nxt;
  logic [2*NUM_TRAINS-1:0] w_d_nxt;

  // Index reached by stepping k places past base, wrapping at NUM_TRAINS.
  function automatic logic [IW-1:0] rr_index(input logic [IW-1:0] base,
                                             input int unsigned k);
    int unsigned s;
    s = 32'(base) + k;
    if (s >= NUM_TRAINS) s = s - NUM_TRAINS;
    return IW'(s);
  endfunction

  assign w_req = r_pending | SR_ENTER;

  // Round-robin search starting just after the previous holder.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int unsigned k = 1; k <= NUM_TRAINS; k++) begin
      if (!w_found && w_req[rr_index(r_last_owner, k)]) begin
        w_found  = 1'b1;
        w_winner = rr_index(r_last_owner, k);
      end
    end
  end

  assign w_grant      = (r_state == S_IDLE) && w_found;
  assign w_owner_exit = (r_state == S_GRANT) && SR_EXIT[r_owner];
  assign w_timeout    = (r_state == S_GRANT) && !SR_EXIT[r_owner] &&
                        (r_timer == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_fault_nxt  = r_fault || w_timeout;
  assign w_owner_nxt  = w_grant ? w_winner : r_owner;

  // The holder's own approach sensor never re-pends it; a grant clears the
  // winner's pending bit even if its sensor is still high on that edge.
  always_comb begin
    w_pending_nxt = r_pending;
    for (int unsigned i = 0; i < NUM_TRAINS; i++) begin
      if (SR_ENTER[i] && !((r_state == S_GRANT) && (r_owner == IW'(i))))
        w_pending_nxt[i] = 1'b1;
      if (w_grant && (w_winner == IW'(i)))
        w_pending_nxt[i] = 1'b0;
    end
  end

  // Stop every requesting train except the one that holds the section next.
  always_comb begin
    w_d_nxt = '0;
    if (!w_fault_nxt) begin
      for (int unsigned i = 0; i < NUM_TRAINS; i++) begin
        if (w_req[i] && (w_owner_nxt != IW'(i)))
          w_d_nxt[2*i +: 2] = 2'b00;
        else
          w_d_nxt[2*i +: 2] = 2'b01;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (RESET) begin
      r_state      <= S_IDLE;
      r_pending    <= '0;
      r_last_owner <= IW'(NUM_TRAINS - 1);
      r_owner      <= '0;
      r_timer      <= '0;
      r_sw         <= '0;
      r_d          <= {NUM_TRAINS{2'b01}};
      r_busy       <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      r_d       <= w_d_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state      <= S_GRANT;
            r_owner      <= w_winner;
            r_last_owner <= w_winner;
            r_sw         <= ROUTE[w_winner*SW_WIDTH +: SW_WIDTH];
            r_busy       <= 1'b1;
            r_timer      <= '0;
          end
        end
        S_GRANT: begin
          if (w_owner_exit) begin
            r_state <= S_CLEAR;
            r_busy  <= 1'b0;
          end else if (w_timeout) begin
            r_state <= S_FAULT;
            r_busy  <= 1'b0;
            r_fault <= 1'b1;
          end else begin
            r_timer <= r_timer + CNT_W'(1);
          end
        end
        S_CLEAR: r_state <= S_IDLE;
        S_FAULT: r_state <= S_FAULT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign SW    = r_sw;
  assign D     = r_d;
  assign OWNER = 3'(r_owner);
  assign BUSY  = r_busy;
  assign FAULT = r_fault;

endmodule

// File: tb/tb_track_section_arbiter.sv
module tb_track_section_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned SWW = 3;
  localparam int unsigned TO  = 8;
  localparam int unsigned CW  = 4;

  logic             Clock = 1'b0;
  logic             RESET;
  logic [N-1:0]     SR_ENTER;
  logic [N-1:0]     SR_EXIT;
  logic [N*SWW-1:0] ROUTE;
  logic [SWW-1:0]   SW;
  logic [2*N-1:0]   D;
  logic [2:0]       OWNER;
  logic             BUSY;
  logic             FAULT;

  always #5 Clock = ~Clock;

  track_section_arbiter #(
    .NUM_TRAINS(N),
    .SW_WIDTH(SWW),
    .TIMEOUT_CYCLES(TO),
    .CNT_W(CW)
  ) dut (
    .Clock(Clock),
    .RESET(RESET),
    .SR_ENTER(SR_ENTER),
    .SR_EXIT(SR_EXIT),
    .ROUTE(ROUTE),
    .SW(SW),
    .D(D),
    .OWNER(OWNER),
    .BUSY(BUSY),
    .FAULT(FAULT)
  );

  int n_vec = 0;
  int n_err = 0;

  localparam logic [2*N-1:0] ALL_GO   = 8'b01010101;
  localparam logic [2*N-1:0] ALL_STOP = 8'b00000000;
  // Directed route table: t3=100, t2=011, t1=010, t0=001
  localparam logic [N*SWW-1:0] DIR_ROUTE = 12'b100_011_010_001;

  typedef struct {
    logic           rst;
    logic [N-1:0]   en;
    logic [N-1:0]   ex;
    logic [SWW-1:0] esw;
    logic [2*N-1:0] ed;
    logic [2:0]     eo;
    logic           eb;
    logic           ef;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [SWW-1:0] esw,
                       input logic [2*N-1:0] ed, input logic [2:0] eo,
                       input logic eb, input logic ef);
    n_vec++;
    if (SW !== esw || D !== ed || OWNER !== eo || BUSY !== eb || FAULT !== ef) begin
      n_err++;
      $display("FAIL %s: got SW=%b D=%b OWNER=%0d BUSY=%b FAULT=%b, want SW=%b D=%b OWNER=%0d BUSY=%b FAULT=%b",
               name, SW, D, OWNER, BUSY, FAULT, esw, ed, eo, eb, ef);
    end
  endtask

  task automatic step(input logic rst, input logic [N-1:0] en, input logic [N-1:0] ex);
    RESET    = rst;
    SR_ENTER = en;
    SR_EXIT  = ex;
    @(posedge Clock);
    #1;
  endtask

  // Behavioural reference: section holder, clearing gap, fault flag,
  // cycles held, and a set of waiting trains.
  bit             m_busy, m_clearing, m_fault;
  int             m_owner, m_last, m_held;
  bit [N-1:0]     m_wait;
  logic [SWW-1:0] m_sw;
  logic [2*N-1:0] m_d;

  task automatic model_edge(input logic rst, input logic [N-1:0] en,
                            input logic [N-1:0] ex, input logic [N*SWW-1:0] rt);
    bit [N-1:0] req;
    bit [N-1:0] nwait;
    int         c;
    if (rst) begin
      m_busy = 0; m_clearing = 0; m_fault = 0;
      m_owner = 0; m_last = N - 1; m_held = 0;
      m_wait = '0; m_sw = '0; m_d = ALL_GO;
      return;
    end
    req   = m_wait | en;
    nwait = m_wait;
    for (int i = 0; i < N; i++)
      if (en[i] && !(m_busy && m_owner == i)) nwait[i] = 1;
    if (m_fault) begin
      // stuck until reset
    end else if (m_busy) begin
      if (ex[m_owner]) begin
        m_busy = 0; m_clearing = 1;
      end else if (m_held == TO - 1) begin
        m_busy = 0; m_fault = 1;
      end else begin
        m_held++;
      end
    end else if (m_clearing) begin
      m_clearing = 0;
    end else if (req != 0) begin
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (req[c]) break;
      end
      nwait[c] = 0;
      m_owner  = c;
      m_last   = c;
      m_sw     = rt[c*SWW +: SWW];
      m_busy   = 1;
      m_held   = 0;
    end
    m_wait = nwait;
    for (int i = 0; i < N; i++)
      m_d[2*i +: 2] = (!m_fault && !(req[i] && i != m_owner)) ? 2'b01 : 2'b00;
  endtask

  initial begin
    RESET    = 1'b1;
    SR_ENTER = '0;
    SR_EXIT  = '0;
    ROUTE    = DIR_ROUTE;

    //                rst  en       ex       sw      d            own eb  ef
    tbl.push_back('{1'b1, 4'b1111, 4'b0000, 3'b000, ALL_GO,      3'd0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 4'b1111, 4'b0000, 3'b000, ALL_GO,      3'd0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'b0000, 4'b0000, 3'b000, ALL_GO,      3'd0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'b0000, 4'b0000, 3'b000, ALL_GO,      3'd0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'b0100, 4'b0000, 3'b011, ALL_GO,      3'd2, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 4'b0000, 4'b0000, 3'b011, ALL_GO,      3'd2, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 4'b0000, 4'b0100, 3'b011, ALL_GO,      3'd2, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'b0000, 4'b0000, 3'b011, ALL_GO,      3'd2, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'b0000, 4'b0000, 3'b011, ALL_GO,      3'd2, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 4'b0000, 4'b0000, 3'b000, ALL_GO,      3'd0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'b1011, 4'b0000, 3'b001, 8'b00010001, 3'd0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 4'b0000, 4'b0000, 3'b001, 8'b00010001, 3'd0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 4'b0000, 4'b0001, 3'b001, 8'b00010001, 3'd0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'b0000, 4'b0000, 3'b001, 8'b00010001, 3'd0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'b0000, 4'b0000, 3'b010, 8'b00010101, 3'd1, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 4'b0010, 4'b0100, 3'b010, 8'b00010101, 3'd1, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 4'b0000, 4'b0000, 3'b010, 8'b00010101, 3'd1, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 4'b0000, 4'b0010, 3'b010, 8'b00010101, 3'd1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'b0000, 4'b0000, 3'b010, 8'b00010101, 3'd1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'b0000, 4'b0000, 3'b100, ALL_GO,      3'd3, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 4'b0000, 4'b1000, 3'b100, ALL_GO,      3'd3, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'b0000, 4'b0000, 3'b100, ALL_GO,      3'd3, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'b0000, 4'b0000, 3'b100, ALL_GO,      3'd3, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'b1001, 4'b0000, 3'b001, 8'b00010101, 3'd0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 4'b0000, 4'b0001, 3'b001, 8'b00010101, 3'd0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'b0000, 4'b0000, 3'b001, 8'b00010101, 3'd0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'b0000, 4'b0000, 3'b100, ALL_GO,      3'd3, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 4'b0000, 4'b1000, 3'b100, ALL_GO,      3'd3, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'b0000, 4'b0000, 3'b100, ALL_GO,      3'd3, 1'b0, 1'b0});

    @(posedge Clock);
    #1;
    for (int v = 0; v < tbl.size(); v++) begin
      step(tbl[v].rst, tbl[v].en, tbl[v].ex);
      check($sformatf("table[%0d]", v), tbl[v].esw, tbl[v].ed, tbl[v].eo,
            tbl[v].eb, tbl[v].ef);
    end

    // Watchdog: train 0 granted (last holder was 3) and never exits.
    step(1'b0, 4'b0001, 4'b0000);
    check("wd_grant", 3'b001, ALL_GO, 3'd0, 1'b1, 1'b0);
    for (int c = 1; c < TO; c++) begin
      step(1'b0, 4'b0000, 4'b0000);
      check($sformatf("wd_hold%0d", c), 3'b001, ALL_GO, 3'd0, 1'b1, 1'b0);
    end
    step(1'b0, 4'b0000, 4'b0000);
    check("wd_fault", 3'b001, ALL_STOP, 3'd0, 1'b0, 1'b1);
    step(1'b0, 4'b1111, 4'b1111);
    check("wd_sticky1", 3'b001, ALL_STOP, 3'd0, 1'b0, 1'b1);
    step(1'b0, 4'b0010, 4'b0000);
    check("wd_sticky2", 3'b001, ALL_STOP, 3'd0, 1'b0, 1'b1);
    step(1'b1, 4'b0000, 4'b0000);
    check("wd_reset", 3'b000, ALL_GO, 3'd0, 1'b0, 1'b0);
    step(1'b0, 4'b0000, 4'b0000);
    check("wd_after_reset", 3'b000, ALL_GO, 3'd0, 1'b0, 1'b0);

    // Exit arriving on the same edge as the timeout: exit wins.
    step(1'b0, 4'b0100, 4'b0000);
    check("race_grant", 3'b011, ALL_GO, 3'd2, 1'b1, 1'b0);
    for (int c = 1; c < TO; c++) begin
      step(1'b0, 4'b0000, 4'b0000);
      check($sformatf("race_hold%0d", c), 3'b011, ALL_GO, 3'd2, 1'b1, 1'b0);
    end
    step(1'b0, 4'b0000, 4'b0100);
    check("race_exit", 3'b011, ALL_GO, 3'd2, 1'b0, 1'b0);
    step(1'b0, 4'b0000, 4'b0000);
    check("race_idle", 3'b011, ALL_GO, 3'd2, 1'b0, 1'b0);

    // Randomized traffic against the reference model.
    ROUTE = N*SWW'($urandom);
    model_edge(1'b1, '0, '0, ROUTE);
    step(1'b1, 4'b0000, 4'b0000);
    check("rand_reset", m_sw, m_d, 3'(m_owner), m_busy, m_fault);
    for (int c = 0; c < 3000; c++) begin
      logic         r;
      logic [N-1:0] en, ex;
      r = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < N; i++) begin
        en[i] = ($urandom_range(0, 5) == 0);
        ex[i] = ($urandom_range(0, 3) == 0);
      end
      ROUTE = N*SWW'($urandom);
      model_edge(r, en, ex, ROUTE);
      step(r, en, ex);
      check($sformatf("rand[%0d]", c), m_sw, m_d, 3'(m_owner), m_busy, m_fault);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
